valrdy_deserializer: RTL and testbench
======================================

// Module: valrdy_deserializer
// PURPOSE
//  Receive end of a serialized val/rdy channel: accepts NBEATS narrow beats on the
//  snd_* side and presents them as one wide message on the rcv_* side.
//  Sits between a narrow link or serializer and a wide val/rdy consumer.
//  Complements the single-entry val/rdy queue stage; same snd_*/rcv_* convention.
// PARAMETERS
//  width   32  bits per incoming beat
//  NBEATS  4   beats per wide message; legal range >= 1
// PORTS
//  CLK      in   1             clock; all state updates on the rising edge
//  reset_n  in   1             reset, asynchronous assert, active-low
//  snd_val  in   1             incoming beat valid
//  snd_rdy  out  1             block can accept a beat
//  snd_msg  in   width         incoming beat payload
//  rcv_val  out  1             assembled wide message valid
//  rcv_rdy  in   1             consumer accepts the wide message
//  rcv_msg  out  width*NBEATS  assembled message; beat k at [k*width +: width]
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=RECV, cnt=0, rcv_val=0, rcv_msg=0.
//    snd_rdy=0 while reset_n=0.
//    A partially assembled message is discarded; no beat is accepted during reset.
//  - cnt: beat index, width max(1,$clog2(NBEATS)); range 0..NBEATS-1, never wraps past.
//  - Transfers: a beat transfers when snd_val & snd_rdy at the edge.
//    The message transfers when rcv_val & rcv_rdy at the edge.
//  - State RECV: snd_rdy=1, rcv_val=0.
//    On a beat transfer: store snd_msg at slot cnt.
//    If cnt==NBEATS-1: cnt<=0, go to SEND. Otherwise cnt<=cnt+1.
//    snd_val=0 leaves state, cnt and data unchanged (gaps allowed).
//  - State SEND: rcv_val=1; rcv_msg is held stable until it transfers.
//    snd_rdy depends on the OVERLAP option below.
//    On a message transfer, go to RECV (or per the OVERLAP option).
//  - Ordering: first beat received is placed in the LSBs.
//  - NBEATS=1: every accepted beat goes directly to SEND; cnt stays 0.
//  - Latency: rcv_val rises the cycle after the last beat transfers.
//    No combinational snd->rcv path.
//  - Slots not yet written in RECV hold stale data; rcv_msg is meaningful only when rcv_val=1.
//  - snd_msg is ignored when no beat transfers; rcv_rdy is ignored in RECV.
// CONFIGURATION
//  VALRDY_DESER_OVERLAP_EN
//   undefined:
//    - snd_rdy=0 in SEND, so throughput is 1 message per NBEATS+1 cycles.
//    - No combinational in->out paths.
//   defined:
//    - In SEND, snd_rdy=rcv_rdy (combinational path rcv_rdy->snd_rdy).
//    - When the message and a beat transfer in the same edge: the beat is stored at slot 0.
//      If NBEATS>1: go to RECV with cnt=1. If NBEATS=1: stay in SEND with the new message.
//    - Message transfer with no beat: go to RECV with cnt=0.
//    - Throughput is 1 message per NBEATS cycles.
// TESTING
//  1. reset_n=0 mid-message after 2 beats, release, send 4 beats
//     -> the first rcv_msg equals only the new 4 beats; rcv_val=0 and snd_rdy=0 during reset.
//  2. width=8, NBEATS=4, beats 11,22,33,44 back-to-back with rcv_rdy=1
//     -> rcv_msg=32'h44332211, rcv_val high exactly 1 cycle, on cycle 5.
//  3. Same beats, then rcv_rdy=0 for 5 cycles
//     -> rcv_val and rcv_msg stay stable; snd_rdy=0 (macro off).
//     Release -> transfer occurs; snd_rdy=1 the next cycle.
//  4. snd_val toggled 1,0,0,1,1,0,1 -> the message assembles correctly across gaps;
//     cnt advances only on transfers.
//  5. NBEATS=1, continuous beats A,B,C with rcv_rdy=1
//     -> outputs A,B,C on alternate cycles (macro off) or every cycle (macro on).
//  6. VALRDY_DESER_OVERLAP_EN defined, NBEATS=4, continuous stream of 3 messages
//     -> 3 rcv transfers in 12 cycles; the first beat of message 2 lands in slot 0 during SEND.

Source files
------------

// File: rtl/valrdy_deserializer.sv
// Receive side of a serialized val/rdy link: gathers NBEATS narrow beats into one wide message.
// Optional macro VALRDY_DESER_OVERLAP_EN lets the first beat of the next message land while the current one leaves.
module valrdy_deserializer #(
    parameter int width  = 32,
    parameter int NBEATS = 4
) (
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic                      snd_val,
    output logic                      snd_rdy,
    input  logic [width-1:0]          snd_msg,
    output logic                      rcv_val,
    input  logic                      rcv_rdy,
    output logic [width*NBEATS-1:0]   rcv_msg
);

    localparam int               CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

    typedef enum logic {
        RECV = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_en;
    logic [CNT_W-1:0] wr_idx;
    logic             beat_xfer;
    logic             msg_xfer;
    logic [width-1:0] slot [NBEATS];

    assign rcv_val   = (state == SEND);
    assign beat_xfer = snd_val & snd_rdy;
    assign msg_xfer  = rcv_val & rcv_rdy;

    // reset_n gates snd_rdy directly so no beat can be taken while reset is held
    always_comb begin
        snd_rdy = 1'b0;
        if (reset_n) begin
            case (state)
                RECV:    snd_rdy = 1'b1;
`ifdef VALRDY_DESER_OVERLAP_EN
                SEND:    snd_rdy = rcv_rdy;
`endif
                default: snd_rdy = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = cnt;
        case (state)
            RECV: begin
                if (beat_xfer) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        state_nxt = SEND;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            SEND: begin
                if (msg_xfer) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
`ifdef VALRDY_DESER_OVERLAP_EN
                    // a beat arriving with the departing message starts the next one at slot 0
                    if (beat_xfer) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (NBEATS > 1) begin
                            cnt_nxt = CNT_W'(1);
                        end else begin
                            state_nxt = SEND;
                        end
                    end
`endif
                end
            end
            default: begin
                state_nxt = RECV;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= RECV;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // first beat received sits in the least significant slot
    for (genvar g = 0; g < NBEATS; g++) begin : g_slot
        always_ff @(posedge CLK or negedge reset_n) begin
            if (!reset_n) begin
                slot[g] <= '0;
            end else if (wr_en && (wr_idx == CNT_W'(g))) begin
                slot[g] <= snd_msg;
            end
        end
        assign rcv_msg[g*width +: width] = slot[g];
    end

endmodule

// File: tb/tb_valrdy_deserializer.sv
// Directed bench for valrdy_deserializer: a width=8/NBEATS=4 instance and a width=8/NBEATS=1 instance.
// Expectations follow VALRDY_DESER_OVERLAP_EN when the bench is built with it defined.
module tb_valrdy_deserializer;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        a_snd_val, a_snd_rdy, a_rcv_val, a_rcv_rdy;
    logic [7:0]  a_snd_msg;
    logic [31:0] a_rcv_msg;
    logic        b_snd_val, b_snd_rdy, b_rcv_val, b_rcv_rdy;
    logic [7:0]  b_snd_msg;
    logic [7:0]  b_rcv_msg;

    int vectors     = 0;
    int miscompares = 0;

    valrdy_deserializer #(.width(8), .NBEATS(4)) u_a (
        .CLK(CLK), .reset_n(reset_n),
        .snd_val(a_snd_val), .snd_rdy(a_snd_rdy), .snd_msg(a_snd_msg),
        .rcv_val(a_rcv_val), .rcv_rdy(a_rcv_rdy), .rcv_msg(a_rcv_msg)
    );

    valrdy_deserializer #(.width(8), .NBEATS(1)) u_b (
        .CLK(CLK), .reset_n(reset_n),
        .snd_val(b_snd_val), .snd_rdy(b_snd_rdy), .snd_msg(b_snd_msg),
        .rcv_val(b_rcv_val), .rcv_rdy(b_rcv_rdy), .rcv_msg(b_rcv_msg)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge passes; returns at the following falling edge
    task automatic cyc();
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0]  beats [4];
        logic [7:0]  bvals [3];
        logic [31:0] exp_msgs [3];
        int          nx;

        reset_n   = 1'b0;
        a_snd_val = 1'b0; a_snd_msg = 8'h00; a_rcv_rdy = 1'b1;
        b_snd_val = 1'b0; b_snd_msg = 8'h00; b_rcv_rdy = 1'b1;
        cyc();
        chk("rst_a_rcv_val", a_rcv_val, 1'b0);
        chk("rst_a_snd_rdy", a_snd_rdy, 1'b0);
        chk("rst_a_rcv_msg", a_rcv_msg, 32'h0);
        chk("rst_b_rcv_val", b_rcv_val, 1'b0);
        chk("rst_b_snd_rdy", b_snd_rdy, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_snd_rdy", a_snd_rdy, 1'b1);

        // test 1: reset in the middle of a message discards the partial beats
        @(negedge CLK);
        a_snd_val = 1'b1; a_snd_msg = 8'hAA; cyc();
        a_snd_msg = 8'hBB; cyc();
        a_snd_msg = 8'hEE; reset_n = 1'b0;
        #1;
        chk("t1_rst_snd_rdy", a_snd_rdy, 1'b0);
        chk("t1_rst_rcv_val", a_rcv_val, 1'b0);
        chk("t1_rst_rcv_msg", a_rcv_msg, 32'h0);
        cyc();
        chk("t1_rst_hold_rcv_val", a_rcv_val, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_snd_msg = 8'(i + 1);
            cyc();
        end
        a_snd_val = 1'b0;
        chk("t1_rcv_val", a_rcv_val, 1'b1);
        chk("t1_rcv_msg", a_rcv_msg, 32'h04030201);
        cyc();
        chk("t1_done_rcv_val", a_rcv_val, 1'b0);
        chk("t1_done_snd_rdy", a_snd_rdy, 1'b1);

        // test 2: back-to-back beats, rcv_val high exactly on the cycle after the 4th beat
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        a_rcv_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_snd_val = 1'b1; a_snd_msg = beats[i];
            cyc();
            if (i < 3) chk($sformatf("t2_rcv_val_c%0d", i + 1), a_rcv_val, 1'b0);
        end
        a_snd_val = 1'b0;
        chk("t2_rcv_val_c5", a_rcv_val, 1'b1);
        chk("t2_rcv_msg", a_rcv_msg, 32'h44332211);
        cyc();
        chk("t2_rcv_val_c6", a_rcv_val, 1'b0);

        // test 3: consumer stalls 5 cycles while the sender keeps offering junk
        a_rcv_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_snd_val = 1'b1; a_snd_msg = beats[i];
            cyc();
        end
        a_snd_msg = 8'h99;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_stall_rcv_val_%0d", i), a_rcv_val, 1'b1);
            chk($sformatf("t3_stall_rcv_msg_%0d", i), a_rcv_msg, 32'h44332211);
            chk($sformatf("t3_stall_snd_rdy_%0d", i), a_snd_rdy, 1'b0);
            cyc();
        end
        a_snd_val = 1'b0; a_rcv_rdy = 1'b1;
        #1;
        chk("t3_release_rcv_msg", a_rcv_msg, 32'h44332211);
        cyc();
        chk("t3_after_rcv_val", a_rcv_val, 1'b0);
        chk("t3_after_snd_rdy", a_snd_rdy, 1'b1);

        // test 4: gapped beats, snd_val pattern 1,0,0,1,1,0,1; rcv_rdy ignored in RECV
        a_rcv_rdy = 1'b1;
        a_snd_val = 1'b1; a_snd_msg = 8'hA1; cyc();
        a_snd_val = 1'b0; a_snd_msg = 8'hF0; cyc();
        a_snd_val = 1'b0; a_snd_msg = 8'hF1; cyc();
        a_snd_val = 1'b1; a_snd_msg = 8'hB2; cyc();
        a_snd_val = 1'b1; a_snd_msg = 8'hC3; cyc();
        a_snd_val = 1'b0; a_snd_msg = 8'hF2; cyc();
        chk("t4_gap_rcv_val", a_rcv_val, 1'b0);
        a_snd_val = 1'b1; a_snd_msg = 8'hD4; cyc();
        a_snd_val = 1'b0;
        chk("t4_rcv_val", a_rcv_val, 1'b1);
        chk("t4_rcv_msg", a_rcv_msg, 32'hD4C3B2A1);
        cyc();
        chk("t4_done_rcv_val", a_rcv_val, 1'b0);

        // test 5: single-beat messages A,B,C with the sender always valid
        bvals[0] = 8'h0A; bvals[1] = 8'h0B; bvals[2] = 8'h0C;
        b_rcv_rdy = 1'b1;
        b_snd_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_snd_msg = bvals[i];
            cyc();
            chk($sformatf("t5_rcv_val_%0d", i), b_rcv_val, 1'b1);
            chk($sformatf("t5_rcv_msg_%0d", i), b_rcv_msg, bvals[i]);
`ifdef VALRDY_DESER_OVERLAP_EN
            chk($sformatf("t5_snd_rdy_%0d", i), b_snd_rdy, 1'b1);
`else
            chk($sformatf("t5_snd_rdy_%0d", i), b_snd_rdy, 1'b0);
            cyc();
            chk($sformatf("t5_gap_rcv_val_%0d", i), b_rcv_val, 1'b0);
            chk($sformatf("t5_gap_snd_rdy_%0d", i), b_snd_rdy, 1'b1);
`endif
        end
        b_snd_val = 1'b0;
        cyc();
        chk("t5_idle_rcv_val", b_rcv_val, 1'b0);

`ifdef VALRDY_DESER_OVERLAP_EN
        // test 6: continuous stream of 3 messages, one beat every cycle
        exp_msgs[0] = 32'h13121110;
        exp_msgs[1] = 32'h17161514;
        exp_msgs[2] = 32'h1B1A1918;
        nx = 0;
        a_rcv_rdy = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (a_rcv_val) begin
                if (nx < 3) chk($sformatf("t6_msg_%0d", nx), a_rcv_msg, exp_msgs[nx]);
                nx++;
            end
            if (c < 12) begin
                a_snd_val = 1'b1; a_snd_msg = 8'(8'h10 + c);
                #1;
                chk($sformatf("t6_snd_rdy_c%0d", c), a_snd_rdy, 1'b1);
            end else begin
                a_snd_val = 1'b0;
            end
            cyc();
        end
        chk("t6_xfer_count", 64'(nx), 64'd3);
        chk("t6_end_rcv_val", a_rcv_val, 1'b0);
`else
        exp_msgs[0] = 32'h0;
        nx = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
